// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg
// Default 640x480@60 Hz raster constants (porches, sync widths, totals),
// sync polarity encodings and a small helper that maps a sync window hit
// onto the pin level for a given polarity.
// No ports. Shared by vga_sync_gen_if, vga_axis_gen and vga_sync_gen.
package vga_timing_pkg;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  localparam int DEF_H_TOTAL  = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int DEF_V_TOTAL  = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  localparam int DEF_CNT_W    = 10;

  localparam bit SYNC_ACTIVE_LOW  = 1'b0;
  localparam bit SYNC_ACTIVE_HIGH = 1'b1;

  // Pin level for a sync output: asserted follows pol, idle is its inverse.
  function automatic bit sync_level(input bit pol, input bit asserted);
    return asserted ? pol : ~pol;
  endfunction

endpackage

// File: rtl/vga_sync_gen_if.sv
// vga_sync_gen_if
// Bundles the raster timing outputs and the pixel advance enable.
//   master (generator): in ce; out hsync, vsync, video_on, x, y,
//                       line_start, frame_start [, frame_cnt]
//   slave  (consumer) : mirror of master
// Optional macro VGA_SYNC_FRAME_CNT_EN adds the 16-bit frame_cnt signal.
interface vga_sync_gen_if
  import vga_timing_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) ();

  logic             ce;
  logic             hsync;
  logic             vsync;
  logic             video_on;
  logic [CNT_W-1:0] x;
  logic [CNT_W-1:0] y;
  logic             line_start;
  logic             frame_start;

`ifdef VGA_SYNC_FRAME_CNT_EN
  logic [15:0]      frame_cnt;

  modport master (input ce, output hsync, vsync, video_on, x, y,
                  line_start, frame_start, frame_cnt);
  modport slave  (output ce, input hsync, vsync, video_on, x, y,
                  line_start, frame_start, frame_cnt);
`else
  modport master (input ce, output hsync, vsync, video_on, x, y,
                  line_start, frame_start);
  modport slave  (output ce, input hsync, vsync, video_on, x, y,
                  line_start, frame_start);
`endif

endinterface

// File: rtl/vga_axis_gen.sv
// vga_axis_gen
// One raster axis: position counter that wraps at TOTAL, registered sync
// window and active-area decode, and a combinational wrap strobe.
//   clk, rst : clock, synchronous active-high reset
//   adv      : advance the position by one this edge
//   cnt      : current position (resets to TOTAL-1)
//   sync     : sync pin level for the current position
//   active   : position is below ACTIVE
//   wrap     : adv while at TOTAL-1, i.e. this edge moves cnt to 0
module vga_axis_gen
  import vga_timing_pkg::*;
#(
  parameter int TOTAL      = DEF_H_TOTAL,
  parameter int ACTIVE     = DEF_H_ACTIVE,
  parameter int SYNC_START = DEF_H_ACTIVE + DEF_H_FP,
  parameter int SYNC_LEN   = DEF_H_SYNC,
  parameter bit SYNC_POL   = SYNC_ACTIVE_LOW,
  parameter int CNT_W      = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             adv,
  output logic [CNT_W-1:0] cnt,
  output logic             sync,
  output logic             active,
  output logic             wrap
);

  localparam logic [CNT_W-1:0] LAST    = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] ACT_END = CNT_W'(ACTIVE);
  localparam logic [CNT_W-1:0] SYNC_LO = CNT_W'(SYNC_START);
  localparam logic [CNT_W-1:0] SYNC_HI = CNT_W'(SYNC_START + SYNC_LEN - 1);

  logic [CNT_W-1:0] cnt_nxt;
  logic             in_sync;

  // Decode from the next count so sync/active land in the same cycle as cnt.
  always_comb begin
    wrap    = adv && (cnt == LAST);
    cnt_nxt = cnt;
    if (wrap) begin
      cnt_nxt = '0;
    end else if (adv) begin
      cnt_nxt = cnt + 1'b1;
    end
    in_sync = (cnt_nxt >= SYNC_LO) && (cnt_nxt <= SYNC_HI);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= LAST;
      sync   <= sync_level(SYNC_POL, 1'b0);
      active <= 1'b0;
    end else begin
      cnt    <= cnt_nxt;
      sync   <= sync_level(SYNC_POL, in_sync);
      active <= (cnt_nxt < ACT_END);
    end
  end

endmodule

// File: rtl/vga_sync_gen.sv
// vga_sync_gen
// VGA raster timing generator (default 640x480@60 Hz on a 25 MHz clock).
// Horizontal axis advances on ce, vertical axis on horizontal wrap; all
// outputs are registered and aligned with x/y.
//   clk : pixel clock
//   rst : synchronous active-high reset (into last pixel of a frame)
//   vif : vga_sync_gen_if.master (ce in; hsync, vsync, video_on, x, y,
//         line_start, frame_start [, frame_cnt] out)
// Optional macro VGA_SYNC_FRAME_CNT_EN: 16-bit frame counter that steps on
// the same edge that raises frame_start.
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter bit SYNC_POL = SYNC_ACTIVE_LOW,
  parameter int CNT_W    = DEF_CNT_W
) (
  input logic            clk,
  input logic            rst,
  vga_sync_gen_if.master vif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  logic [CNT_W-1:0] x_cnt;
  logic [CNT_W-1:0] y_cnt;
  logic             h_sync, v_sync;
  logic             h_act, v_act;
  logic             h_wrap, v_wrap;
  logic             line_start_q, frame_start_q;

  vga_axis_gen #(
    .TOTAL      (H_TOTAL),
    .ACTIVE     (H_ACTIVE),
    .SYNC_START (H_ACTIVE + H_FP),
    .SYNC_LEN   (H_SYNC),
    .SYNC_POL   (SYNC_POL),
    .CNT_W      (CNT_W)
  ) u_h (
    .clk    (clk),
    .rst    (rst),
    .adv    (vif.ce),
    .cnt    (x_cnt),
    .sync   (h_sync),
    .active (h_act),
    .wrap   (h_wrap)
  );

  vga_axis_gen #(
    .TOTAL      (V_TOTAL),
    .ACTIVE     (V_ACTIVE),
    .SYNC_START (V_ACTIVE + V_FP),
    .SYNC_LEN   (V_SYNC),
    .SYNC_POL   (SYNC_POL),
    .CNT_W      (CNT_W)
  ) u_v (
    .clk    (clk),
    .rst    (rst),
    .adv    (h_wrap),
    .cnt    (y_cnt),
    .sync   (v_sync),
    .active (v_act),
    .wrap   (v_wrap)
  );

  // v_wrap implies h_wrap, so frame_start is always a subset of line_start.
  always_ff @(posedge clk) begin
    if (rst) begin
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      line_start_q  <= h_wrap;
      frame_start_q <= v_wrap;
    end
  end

`ifdef VGA_SYNC_FRAME_CNT_EN
  logic [15:0] frame_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt_q <= '0;
    end else if (v_wrap) begin
      frame_cnt_q <= frame_cnt_q + 16'd1;
    end
  end

  assign vif.frame_cnt = frame_cnt_q;
`endif

  assign vif.x           = x_cnt;
  assign vif.y           = y_cnt;
  assign vif.hsync       = h_sync;
  assign vif.vsync       = v_sync;
  assign vif.video_on    = h_act & v_act;
  assign vif.line_start  = line_start_q;
  assign vif.frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen
// Default-timing instance driven from a directed vector table plus
// hand-written reset / enable sequences; a reduced-timing instance
// (13x9 raster, active-high sync) is checked cycle by cycle against a
// small reference model so vertical sync and frame wrap are reachable.
module tb_vga_sync_gen;
  import vga_timing_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  vga_sync_gen_if #(.CNT_W(10)) vm ();
  vga_sync_gen_if #(.CNT_W(4))  vs ();

  vga_sync_gen dut (
    .clk (clk),
    .rst (rst),
    .vif (vm)
  );

  // H: 6 active, 2 fp, 3 sync, 2 bp -> total 13, hsync at x=8..10
  // V: 4 active, 1 fp, 2 sync, 2 bp -> total 9,  vsync at y=5..6
  vga_sync_gen #(
    .H_ACTIVE (6), .H_FP (2), .H_SYNC (3), .H_BP (2),
    .V_ACTIVE (4), .V_FP (1), .V_SYNC (2), .V_BP (2),
    .SYNC_POL (1'b1), .CNT_W (4)
  ) dut_s (
    .clk (clk),
    .rst (rst),
    .vif (vs)
  );

  typedef struct {
    bit ce;
    int n;
    int ex;
    int ey;
    bit eh;
    bit ev;
    bit evo;
    bit els;
    bit efs;
  } vec_t;

  vec_t vt[12];

  task automatic chk(input string nm, input int idx,
                     input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[%0d]: got %0d, expected %0d", nm, idx, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_main(input string nm, input int idx, input int ex, input int ey,
                          input bit eh, input bit ev, input bit evo,
                          input bit els, input bit efs);
    chk({nm, ".x"},           idx, 32'(vm.x),        ex);
    chk({nm, ".y"},           idx, 32'(vm.y),        ey);
    chk({nm, ".hsync"},       idx, 32'(vm.hsync),    32'(eh));
    chk({nm, ".vsync"},       idx, 32'(vm.vsync),    32'(ev));
    chk({nm, ".video_on"},    idx, 32'(vm.video_on), 32'(evo));
    chk({nm, ".line_start"},  idx, 32'(vm.line_start),  32'(els));
    chk({nm, ".frame_start"}, idx, 32'(vm.frame_start), 32'(efs));
  endtask

  initial begin
    int  got;
    int  mx, my, mfc, ce_cnt, last_fs;
    bit  ce_b, exp_ls, exp_fs;

    //        ce  n    x    y  hs vs vo ls fs
    vt[0]  = '{1, 1,   0,   0, 1, 1, 1, 1, 1};
    vt[1]  = '{1, 1,   1,   0, 1, 1, 1, 0, 0};
    vt[2]  = '{1, 638, 639, 0, 1, 1, 1, 0, 0};
    vt[3]  = '{1, 1,   640, 0, 1, 1, 0, 0, 0};
    vt[4]  = '{1, 15,  655, 0, 1, 1, 0, 0, 0};
    vt[5]  = '{1, 1,   656, 0, 0, 1, 0, 0, 0};
    vt[6]  = '{1, 95,  751, 0, 0, 1, 0, 0, 0};
    vt[7]  = '{1, 1,   752, 0, 1, 1, 0, 0, 0};
    vt[8]  = '{0, 5,   752, 0, 1, 1, 0, 0, 0};
    vt[9]  = '{1, 47,  799, 0, 1, 1, 0, 0, 0};
    vt[10] = '{1, 1,   0,   1, 1, 1, 1, 1, 0};
    vt[11] = '{1, 300, 300, 1, 1, 1, 1, 0, 0};

    vm.ce = 1'b0;
    vs.ce = 1'b0;
    rst   = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);

    chk_main("reset", 0, 799, 524, 1, 1, 0, 0, 0);
    chk("s_reset.x",     0, 32'(vs.x),     12);
    chk("s_reset.y",     0, 32'(vs.y),     8);
    chk("s_reset.hsync", 0, 32'(vs.hsync), 0);
    chk("s_reset.vsync", 0, 32'(vs.vsync), 0);
`ifdef VGA_SYNC_FRAME_CNT_EN
    chk("reset.frame_cnt", 0, 32'(vm.frame_cnt), 0);
`endif

    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      vm.ce = vt[i].ce;
      step(vt[i].n);
      chk_main("vec", i, vt[i].ex, vt[i].ey, vt[i].eh, vt[i].ev,
               vt[i].evo, vt[i].els, vt[i].efs);
    end

    // Reset mid-line with ce still high: reset state, no strobes.
    rst = 1'b1;
    step(1);
    chk_main("mid_rst", 0, 799, 524, 1, 1, 0, 0, 0);
    rst = 1'b0;
    step(1);
    chk_main("recover", 0, 0, 0, 1, 1, 1, 1, 1);

    // ce low: position holds, strobe drops.
    vm.ce = 1'b0;
    step(1);
    chk_main("ce_hold", 0, 0, 0, 1, 1, 1, 0, 0);

    // Alternating ce: one line takes 1600 clocks.
    got = -1;
    for (int c = 2; c <= 4000; c++) begin
      vm.ce = (c % 2 == 0);
      step(1);
      if (c == 1000) chk("toggle.x", c, 32'(vm.x), 500);
      if (vm.line_start) begin
        got = c;
        break;
      end
    end
    chk("toggle.period", 0, got, 1600);
    chk("toggle.y", 0, 32'(vm.y), 1);
    vm.ce = 1'b1;
    step(1);
    chk("toggle.ls_one_cycle", 0, 32'(vm.line_start), 0);
    chk("toggle.x_after", 0, 32'(vm.x), 1);

    // Reduced raster against a reference model.
    vm.ce = 1'b0;
    rst   = 1'b1;
    step(2);
    rst     = 1'b0;
    mx      = 12;
    my      = 8;
    mfc     = 0;
    ce_cnt  = 0;
    last_fs = -1;
    for (int c = 0; c < 300; c++) begin
      ce_b  = (c % 7 != 3);
      vs.ce = ce_b;
      step(1);
      exp_ls = 1'b0;
      exp_fs = 1'b0;
      if (ce_b) begin
        ce_cnt++;
        if (mx == 12) begin
          mx     = 0;
          exp_ls = 1'b1;
          if (my == 8) begin
            my     = 0;
            exp_fs = 1'b1;
          end else begin
            my++;
          end
        end else begin
          mx++;
        end
      end
      if (exp_fs) mfc++;
      chk("s.x",           c, 32'(vs.x),           mx);
      chk("s.y",           c, 32'(vs.y),           my);
      chk("s.hsync",       c, 32'(vs.hsync),       32'(mx >= 8 && mx <= 10));
      chk("s.vsync",       c, 32'(vs.vsync),       32'(my >= 5 && my <= 6));
      chk("s.video_on",    c, 32'(vs.video_on),    32'(mx < 6 && my < 4));
      chk("s.line_start",  c, 32'(vs.line_start),  32'(exp_ls));
      chk("s.frame_start", c, 32'(vs.frame_start), 32'(exp_fs));
`ifdef VGA_SYNC_FRAME_CNT_EN
      chk("s.frame_cnt",   c, 32'(vs.frame_cnt),   mfc & 32'hffff);
`endif
      if (vs.frame_start) begin
        if (last_fs >= 0) chk("s.frame_period", c, ce_cnt - last_fs, 117);
        last_fs = ce_cnt;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
